// File: rtl/seq_pattern_tx.sv
// Serial frame transmitter: preamble, then latched payload MSB first, then guard zeros.
// One bit per clock on a registered line that idles at 0.
module seq_pattern_tx #(
  parameter int unsigned      DATA_W    = 8,
  parameter int unsigned      PRE_W     = 6,
  parameter logic [PRE_W-1:0] PREAMBLE  = 6'b111001,
  parameter int unsigned      GUARD_LEN = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              out,
  output logic              busy,
  output logic              sync,
  output logic              done
);

  localparam int unsigned MAX_A     = (PRE_W > DATA_W) ? PRE_W : DATA_W;
  localparam int unsigned MAX_B     = (MAX_A > GUARD_LEN) ? MAX_A : GUARD_LEN;
  localparam int unsigned MAX_C     = (MAX_B > 2) ? MAX_B : 2;
  localparam int unsigned CW        = $clog2(MAX_C);
  localparam int unsigned GUARD_CNT = (GUARD_LEN > 0) ? GUARD_LEN - 1 : 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    PAY   = 2'd2,
    GUARD = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              out_q, out_d;
  logic              busy_q, busy_d;
  logic              sync_q, sync_d;
  logic              done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          shreg_d = data;
          cnt_d   = CW'(PRE_W - 1);
          state_d = PRE;
        end
      end
      PRE: begin
        if (cnt_q == '0) begin
          cnt_d   = CW'(DATA_W - 1);
          state_d = PAY;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      PAY: begin
        shreg_d = shreg_q << 1;
        if (cnt_q == '0) begin
          if (GUARD_LEN == 0) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = CW'(GUARD_CNT);
            state_d = GUARD;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      GUARD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so the registered line
    // carries the bit belonging to the state being entered.
    out_d  = 1'b0;
    if (state_d == PRE) begin
      out_d = PREAMBLE[cnt_d];
    end else if (state_d == PAY) begin
      out_d = shreg_d[DATA_W-1];
    end
    busy_d = (state_d != IDLE);
    sync_d = (state_d == PRE);
    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
      sync_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
      sync_q  <= sync_d;
      done_q  <= done_d;
    end
  end

  assign out  = out_q;
  assign busy = busy_q;
  assign sync = sync_q;
  assign done = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed scoreboard bench for seq_pattern_tx: default build plus a no-guard build,
// with a bench-side 111001 window detector watching the default build's line.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic [7:0] data, data0;
  logic       out, busy, sync, done;
  logic       out0, busy0, sync0, done0;

  int checks   = 0;
  int failures = 0;

  // Expected per-cycle {out, busy, sync, done}; an empty queue means idle.
  logic [3:0] q1[$];
  logic [3:0] q0[$];

  logic [5:0] win = '0;
  int det_cnt = 0;
  int det_misaligned = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(
    .DATA_W(8), .PRE_W(6), .PREAMBLE(6'b111001), .GUARD_LEN(2)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data(data),
    .out(out), .busy(busy), .sync(sync), .done(done)
  );

  seq_pattern_tx #(
    .DATA_W(8), .PRE_W(6), .PREAMBLE(6'b111001), .GUARD_LEN(0)
  ) dut0 (
    .clk(clk), .rst(rst), .start(start0), .data(data0),
    .out(out0), .busy(busy0), .sync(sync0), .done(done0)
  );

  // Loopback detector on the serial line, sampled mid-cycle.
  always @(negedge clk) begin
    win <= {win[4:0], out};
    if ({win[4:0], out} == 6'b111001) begin
      det_cnt <= det_cnt + 1;
      if (!sync) det_misaligned <= det_misaligned + 1;
    end
  end

  task automatic push_frame(input bit sel, input logic [7:0] d, input int glen);
    logic [5:0] pre;
    logic [3:0] e;
    pre = 6'b111001;
    for (int i = 5; i >= 0; i--) begin
      e = {pre[i], 1'b1, 1'b1, 1'b0};
      if (sel) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 7; i >= 0; i--) begin
      e = {d[i], 1'b1, 1'b0, 1'b0};
      if (sel) q0.push_back(e); else q1.push_back(e);
    end
    for (int i = 0; i < glen; i++) begin
      e = 4'b0100;
      if (sel) q0.push_back(e); else q1.push_back(e);
    end
    e = 4'b0001;
    if (sel) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic cyc(input string tag);
    logic [3:0] exp1, exp0, obs1, obs0;
    @(posedge clk);
    #1;
    exp1 = (q1.size() != 0) ? q1.pop_front() : 4'b0000;
    exp0 = (q0.size() != 0) ? q0.pop_front() : 4'b0000;
    obs1 = {out, busy, sync, done};
    obs0 = {out0, busy0, sync0, done0};
    checks++;
    assert (obs1 === exp1) else begin
      failures++;
      $error("FAIL %s g2 {out,busy,sync,done} got=%b exp=%b", tag, obs1, exp1);
    end
    checks++;
    assert (obs0 === exp0) else begin
      failures++;
      $error("FAIL %s g0 {out,busy,sync,done} got=%b exp=%b", tag, obs0, exp0);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int det_base;
    rst = 1'b1; start = 1'b0; data = '0; start0 = 1'b0; data0 = '0;
    repeat (3) cyc("reset");
    rst = 1'b0;
    cyc("post_reset_idle");

    // Single A5 frame on the default build
    det_base = det_cnt;
    start = 1'b1; data = 8'hA5;
    push_frame(1'b0, 8'hA5, 2);
    cyc("a5_frame");
    start = 1'b0; data = 8'h00;
    repeat (17) cyc("a5_frame");
    check_int("a5_detect_count", det_cnt - det_base, 1);

    // Continuous start: three back-to-back frames, 17-cycle period
    det_base = det_cnt;
    start = 1'b1; data = 8'h00;
    push_frame(1'b0, 8'h00, 2);
    push_frame(1'b0, 8'h00, 2);
    push_frame(1'b0, 8'h00, 2);
    repeat (35) cyc("b2b_frames");
    start = 1'b0;
    repeat (17) cyc("b2b_frames");
    check_int("b2b_detect_count", det_cnt - det_base, 3);
    check_int("detect_misaligned", det_misaligned, 0);

    // Start pulse and data change while busy are ignored
    start = 1'b1; data = 8'hA5;
    push_frame(1'b0, 8'hA5, 2);
    cyc("inflight");
    start = 1'b0;
    repeat (4) cyc("inflight");
    start = 1'b1; data = 8'hFF;
    cyc("inflight");
    start = 1'b0;
    repeat (12) cyc("inflight");

    // Reset at frame cycle 9 aborts the frame with no done pulse
    start = 1'b1; data = 8'hA5;
    push_frame(1'b0, 8'hA5, 2);
    cyc("abort");
    start = 1'b0;
    repeat (8) cyc("abort");
    rst = 1'b1;
    q1.delete();
    cyc("abort_rst");
    rst = 1'b0;
    repeat (3) cyc("abort_idle");
    start = 1'b1; data = 8'h5A;
    push_frame(1'b0, 8'h5A, 2);
    cyc("after_abort");
    start = 1'b0;
    repeat (17) cyc("after_abort");

    // No-guard build: 14-cycle frame, done on cycle 15
    start0 = 1'b1; data0 = 8'h3C;
    push_frame(1'b1, 8'h3C, 0);
    cyc("noguard");
    start0 = 1'b0; data0 = 8'h00;
    repeat (16) cyc("noguard");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
